// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the RAM burst controller and the RAM it drives.
// State encodings are plain constants so legacy netlists keep the same codes.
package ram_ctrl_pkg;

  localparam int RAM_WIDTH = 8;
  localparam int RAM_DEPTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Host request/data bus plus RAM port of the burst controller.
// The slave modport is the controller's view; master is the host+RAM environment.
interface ram_burst_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [LW-1:0]    req_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [WIDTH-1:0] wdata;
  logic             rdata_valid;
  logic [WIDTH-1:0] rdata;
  logic             done;
  logic             err;
  logic             ram_wr_rd;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data_in;
  logic [WIDTH-1:0] ram_data_out;
  logic             ram_full;
  logic             ram_empty;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, wdata_valid, wdata,
           ram_data_out, ram_full, ram_empty,
    output req_ready, wdata_ready, rdata_valid, rdata, done, err,
           ram_wr_rd, ram_addr, ram_data_in
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len, wdata_valid, wdata,
           ram_data_out, ram_full, ram_empty,
    input  req_ready, wdata_ready, rdata_valid, rdata, done, err,
           ram_wr_rd, ram_addr, ram_data_in
  );

endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the single-port RAM: one write or read burst per request,
// consecutive addresses with wrap, write data on valid/ready, read data with a valid strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; req_ready=1
// ST_WRITE | one RAM write per wdata_valid beat until remaining hits 0
// ST_READ  | one RAM read per cycle, no stall, until remaining hits 0
// ST_DONE  | single cycle: done=1, err reports accumulated full/empty hits
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int DEPTH = RAM_DEPTH
) (
  input logic             clk,
  input logic             rst,
  ram_burst_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] remaining;
  logic          err_acc;
  logic          rdata_valid_q;

  logic          beat;
  logic          issue;
  logic [LW-1:0] len_clamped;
  logic [AW-1:0] next_addr;

  assign beat  = (state == ST_WRITE) && bus.wdata_valid;
  assign issue = (state == ST_READ);

  assign len_clamped = (bus.req_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.req_len;

  // Explicit wrap keeps the arithmetic modulo DEPTH even for non-power-of-two depths.
  assign next_addr = (cur_addr == AW'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.wdata_ready = (state == ST_WRITE);
  assign bus.ram_wr_rd   = beat;
  assign bus.ram_addr    = cur_addr;
  assign bus.ram_data_in = bus.wdata;
  assign bus.rdata       = bus.ram_data_out;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.done        = (state == ST_DONE);
  assign bus.err         = (state == ST_DONE) && err_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      err_acc       <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      // The RAM registers its output, so read data trails its address by one cycle.
      rdata_valid_q <= issue;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cur_addr  <= bus.req_addr;
            remaining <= len_clamped;
            err_acc   <= 1'b0;
            if (len_clamped == '0) state <= ST_DONE;
            else if (bus.req_wr)   state <= ST_WRITE;
            else                   state <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (bus.wdata_valid) begin
            cur_addr  <= next_addr;
            remaining <= remaining - 1'b1;
            err_acc   <= err_acc | bus.ram_full;
            if (remaining == LW'(1)) state <= ST_DONE;
          end
        end
        ST_READ: begin
          cur_addr  <= next_addr;
          remaining <= remaining - 1'b1;
          err_acc   <= err_acc | bus.ram_empty;
          if (remaining == LW'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a behavioural single-port RAM; directed bursts feed a
// scoreboard of expected RAM writes, read words and done/err events checked by a monitor.
module tb_ram_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.WIDTH(8), .DEPTH(32)) bus ();

  ram_burst_ctrl #(.WIDTH(8), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural RAM: always accesses, registered read, full/empty from written-word flags.
  logic [7:0]  mem [32] = '{default: '0};
  logic [31:0] vld      = '0;
  logic [7:0]  ram_q    = '0;

  always @(posedge clk) begin
    if (bus.ram_wr_rd) begin
      mem[bus.ram_addr] <= bus.ram_data_in;
      vld[bus.ram_addr] <= 1'b1;
    end else begin
      ram_q <= mem[bus.ram_addr];
    end
  end

  assign bus.ram_data_out = ram_q;
  assign bus.ram_full     = &vld;
  assign bus.ram_empty    = ~|vld;

  typedef struct {logic [4:0] a; logic [7:0] d;} wr_t;
  typedef struct {bit err; bit rv; int lat;} dn_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  dn_t        dq[$];

  logic [7:0]  mem_m [32] = '{default: '0};
  logic [31:0] vld_m      = '0;

  int cyc     = 0;
  int acc_cyc = 0;
  int n_vec   = 0;
  int n_miss  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s unexpected event (t=%0t)", name, $time);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_wr_rd) begin
        if (wq.size() == 0) unexpected("ram_write");
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(bus.ram_addr), 32'(w.a));
          chk("wr_data", 32'(bus.ram_data_in), 32'(w.d));
        end
      end
      if (bus.rdata_valid) begin
        if (rq.size() == 0) unexpected("rdata_valid");
        else chk("rdata", 32'(bus.rdata), 32'(rq.pop_front()));
      end
      if (bus.done) begin
        if (dq.size() == 0) unexpected("done");
        else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_err", 32'(bus.err), 32'(d.err));
          chk("done_rv", 32'(bus.rdata_valid), 32'(d.rv));
          if (d.lat >= 0) chk("done_lat", 32'(cyc - acc_cyc), 32'(d.lat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_at > 0 asserts reset once that many write beats have been taken.
  task automatic burst(input bit wr, input int addr, input int len, input bit toggle,
                       input logic [7:0] d0, input int abort_at);
    int  eff, nbeats, i, t;
    bit  e;
    dn_t dn;
    eff    = (len > 32) ? 32 : len;
    nbeats = (abort_at > 0) ? abort_at : eff;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = 5'(addr);
    bus.req_len   = 6'(len);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      tick();
      t++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    acc_cyc = cyc;
    e = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      logic [4:0] a;
      a = 5'((addr + k) % 32);
      if (wr) begin
        if (&vld_m) e = 1'b1;
        wq.push_back('{a: a, d: d0 + 8'(k)});
        mem_m[a] = d0 + 8'(k);
        vld_m[a] = 1'b1;
      end else begin
        rq.push_back(mem_m[a]);
      end
    end
    if (!wr && eff > 0 && vld_m == '0) e = 1'b1;
    if (abort_at == 0) begin
      dn.err = e;
      dn.rv  = !wr && (eff > 0);
      dn.lat = toggle ? -1 : eff + 1;
      dq.push_back(dn);
    end
    tick();
    bus.req_valid = 1'b0;
    if (wr) begin
      i = 0;
      t = 0;
      while (i < eff && t < 200) begin
        if (abort_at > 0 && i == abort_at) begin
          rst = 1'b0;
          bus.wdata_valid = 1'b0;
          #1;
          chk("abort_wr_rd", 32'(bus.ram_wr_rd), 32'd0);
          chk("abort_done", 32'(bus.done), 32'd0);
          chk("abort_rv", 32'(bus.rdata_valid), 32'd0);
          chk("abort_idle", 32'(bus.req_ready), 32'd1);
          tick();
          tick();
          rst = 1'b1;
          break;
        end
        bus.wdata_valid = toggle ? ((t % 2) == 0) : 1'b1;
        bus.wdata       = d0 + 8'(i);
        if (bus.wdata_valid && bus.wdata_ready) i++;
        tick();
        t++;
      end
      bus.wdata_valid = 1'b0;
    end
    t = 0;
    while ((dq.size() + rq.size() + wq.size()) != 0 && t < 100) begin
      tick();
      t++;
    end
    chk("drain", 32'(dq.size() + rq.size() + wq.size()), 32'd0);
    tick();
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_wr      = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    #20;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wr_rd", 32'(bus.ram_wr_rd), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    burst(1'b0, 5, 3, 1'b0, 8'h00, 0);   // read from an empty RAM -> err
    burst(1'b1, 0, 32, 1'b0, 8'hA0, 0);  // full write A0..BF
    chk("ram_full_after", 32'(bus.ram_full), 32'd1);
    burst(1'b0, 0, 32, 1'b0, 8'h00, 0);  // read back A0..BF
    burst(1'b1, 30, 4, 1'b1, 8'h50, 0);  // wrap with stalled data, RAM full -> err
    burst(1'b0, 30, 4, 1'b0, 8'h00, 0);
    burst(1'b1, 7, 0, 1'b0, 8'h00, 0);   // zero-length write
    burst(1'b0, 9, 0, 1'b0, 8'h00, 0);   // zero-length read
    burst(1'b1, 3, 40, 1'b0, 8'h10, 0);  // clamps to 32
    burst(1'b0, 3, 40, 1'b0, 8'h00, 0);
    burst(1'b1, 0, 10, 1'b0, 8'hE0, 5);  // reset after 5 beats
    burst(1'b0, 0, 6, 1'b0, 8'h00, 0);   // only the 5 aborted-burst words changed

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
